// File: rtl/nasti_stream_sched_pkg.sv
// nasti_stream_sched_pkg: shared types for the stream mover scheduler.
// Slot fields are sized for the widest configuration; users cast down.
package nasti_stream_sched_pkg;

    localparam int SLOT_AW = 64;
    localparam int SLOT_SW = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DROP = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic               busy;
        logic               last;
        logic [SLOT_SW-1:0] dest;
        logic [SLOT_SW-1:0] user;
        logic [SLOT_AW-1:0] addr;
        logic [SLOT_AW-1:0] rem;
    } slot_t;

endpackage

// File: rtl/nasti_stream_mover_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr.
// Returns a one-hot grant, its index and an any-grant flag.
module rr_arbiter
    import nasti_stream_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan upward from ptr with wrap; first requester wins.
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/nasti_stream_mover_sched.sv
// nasti_stream_mover_sched: splits per-requester byte ranges into
// chunk commands for a single data mover, round-robin between slots.
module nasti_stream_mover_sched
    import nasti_stream_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int DEST_WIDTH  = 1,
    parameter int USER_WIDTH  = 1,
    parameter int CHUNK_BYTES = 512
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic                                 enable,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_len,
    input  logic [NUM_REQ-1:0][DEST_WIDTH-1:0]   req_dest,
    input  logic [NUM_REQ-1:0][USER_WIDTH-1:0]   req_user,
    input  logic [NUM_REQ-1:0]                   req_last,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [NUM_REQ-1:0]                   cmpl,
    output logic [NUM_REQ-1:0]                   busy,
    output logic                                 m_valid,
    output logic [ADDR_WIDTH-1:0]                m_addr,
    output logic [ADDR_WIDTH-1:0]                m_len,
    output logic [DEST_WIDTH-1:0]                m_dest,
    output logic [USER_WIDTH-1:0]                m_user,
    output logic                                 m_last,
    input  logic                                 m_ready
);

    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        ~ADDR_WIDTH'(DATA_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] CHUNK = ADDR_WIDTH'(CHUNK_BYTES);

    slot_t                  slot_q [NUM_REQ];
    slot_t                  slot_d [NUM_REQ];
    sched_state_e           state_q, state_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic                   m_valid_q, m_valid_d;
    logic [ADDR_WIDTH-1:0]  m_addr_q, m_addr_d;
    logic [ADDR_WIDTH-1:0]  m_len_q, m_len_d;
    logic [DEST_WIDTH-1:0]  m_dest_q, m_dest_d;
    logic [USER_WIDTH-1:0]  m_user_q, m_user_d;
    logic                   m_last_q, m_last_d;
    logic [NUM_REQ-1:0]     cmpl_q, cmpl_d;

    logic [NUM_REQ-1:0]     elig;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

    // A slot competes only while it still has bytes to move.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = slot_q[i].busy &&
                      (ADDR_WIDTH'(slot_q[i].rem) != '0);
            req_ready[i] = !slot_q[i].busy;
            busy[i]      = slot_q[i].busy;
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req (elig),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    // Next-state: request capture, chunk issue and chunk retirement.
    always_comb begin
        logic [ADDR_WIDTH-1:0] len_m;
        logic [ADDR_WIDTH-1:0] sel_addr;
        logic [ADDR_WIDTH-1:0] sel_rem;
        logic [DEST_WIDTH-1:0] sel_dest;
        logic [USER_WIDTH-1:0] sel_user;
        logic                  sel_last;
        logic [ADDR_WIDTH-1:0] cur_addr;
        logic [ADDR_WIDTH-1:0] rem_next;

        slot_d    = slot_q;
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_d     = gnt_q;
        m_valid_d = m_valid_q;
        m_addr_d  = m_addr_q;
        m_len_d   = m_len_q;
        m_dest_d  = m_dest_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
        cmpl_d    = '0;
        len_m     = '0;
        sel_addr  = '0;
        sel_rem   = '0;
        sel_dest  = '0;
        sel_user  = '0;
        sel_last  = 1'b0;
        cur_addr  = ADDR_WIDTH'(slot_q[gnt_q].addr);
        rem_next  = ADDR_WIDTH'(slot_q[gnt_q].rem) - m_len_q;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_addr = ADDR_WIDTH'(slot_q[i].addr);
                sel_rem  = ADDR_WIDTH'(slot_q[i].rem);
                sel_dest = DEST_WIDTH'(slot_q[i].dest);
                sel_user = USER_WIDTH'(slot_q[i].user);
                sel_last = slot_q[i].last;
            end
        end

        // Zero-length requests retire at once and never go busy.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !slot_q[i].busy) begin
                len_m = req_len[i] & ALIGN_MASK;
                slot_d[i].addr = SLOT_AW'(req_addr[i] & ALIGN_MASK);
                slot_d[i].rem  = SLOT_AW'(len_m);
                slot_d[i].dest = SLOT_SW'(req_dest[i]);
                slot_d[i].user = SLOT_SW'(req_user[i]);
                slot_d[i].last = req_last[i];
                slot_d[i].busy = (len_m != '0);
                cmpl_d[i]      = (len_m == '0);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (enable && arb_any) begin
                    m_addr_d  = sel_addr;
                    m_len_d   = (sel_rem > CHUNK) ? CHUNK : sel_rem;
                    m_last_d  = sel_last && (sel_rem <= CHUNK);
                    m_dest_d  = sel_dest;
                    m_user_d  = sel_user;
                    m_valid_d = 1'b1;
                    gnt_d     = arb_idx;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    slot_d[gnt_q].addr = SLOT_AW'(cur_addr + m_len_q);
                    slot_d[gnt_q].rem  = SLOT_AW'(rem_next);
                    if (rem_next == '0) begin
                        slot_d[gnt_q].busy = 1'b0;
                        cmpl_d[gnt_q]      = 1'b1;
                    end
                    rr_d    = IDX_W'((int'(gnt_q) + 1) % NUM_REQ);
                    state_d = ST_WAIT_DROP;
                end
            end
            ST_WAIT_DROP: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // All scheduler state, including registered command outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            rr_q      <= '0;
            gnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_len_q   <= '0;
            m_dest_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
            cmpl_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_q     <= gnt_d;
            m_valid_q <= m_valid_d;
            m_addr_q  <= m_addr_d;
            m_len_q   <= m_len_d;
            m_dest_q  <= m_dest_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
            cmpl_q    <= cmpl_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign cmpl    = cmpl_q;
    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_len   = m_len_q;
    assign m_dest  = m_dest_q;
    assign m_user  = m_user_q;
    assign m_last  = m_last_q;

endmodule

// File: tb/tb_nasti_stream_mover_sched.sv
// tb_nasti_stream_mover_sched: randomized and directed checks of the
// chunk scheduler against a queue-level reference of pending bytes.
module tb_nasti_stream_mover_sched;

    localparam int NREQ  = 3;
    localparam int AW    = 32;
    localparam int DW    = 64;
    localparam int DSW   = 2;
    localparam int USW   = 3;
    localparam int CHUNK = 512;

    logic                       aclk = 1'b0;
    logic                       areset;
    logic                       enable;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][AW-1:0]    req_addr;
    logic [NREQ-1:0][AW-1:0]    req_len;
    logic [NREQ-1:0][DSW-1:0]   req_dest;
    logic [NREQ-1:0][USW-1:0]   req_user;
    logic [NREQ-1:0]            req_last;
    logic [NREQ-1:0]            req_ready;
    logic [NREQ-1:0]            cmpl;
    logic [NREQ-1:0]            busy;
    logic                       m_valid;
    logic [AW-1:0]              m_addr;
    logic [AW-1:0]              m_len;
    logic [DSW-1:0]             m_dest;
    logic [USW-1:0]             m_user;
    logic                       m_last;
    logic                       m_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: bytes still owed per requester plus the rr pointer.
    logic [AW-1:0]  md_addr [NREQ];
    logic [AW-1:0]  md_rem  [NREQ];
    logic           md_last [NREQ];
    logic [DSW-1:0] md_dest [NREQ];
    logic [USW-1:0] md_user [NREQ];
    int             md_rr;

    logic [AW-1:0]  st_addr [NREQ];
    logic [AW-1:0]  st_len  [NREQ];
    logic           st_last [NREQ];
    logic [DSW-1:0] st_dest [NREQ];
    logic [USW-1:0] st_user [NREQ];

    always #5 aclk = ~aclk;

    nasti_stream_mover_sched #(
        .NUM_REQ     (NREQ),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .DEST_WIDTH  (DSW),
        .USER_WIDTH  (USW),
        .CHUNK_BYTES (CHUNK)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .enable    (enable),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_dest  (req_dest),
        .req_user  (req_user),
        .req_last  (req_last),
        .req_ready (req_ready),
        .cmpl      (cmpl),
        .busy      (busy),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_len     (m_len),
        .m_dest    (m_dest),
        .m_user    (m_user),
        .m_last    (m_last),
        .m_ready   (m_ready)
    );

    function automatic int model_pick();
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (md_rr + k) % NREQ;
            if (md_rem[j] != 0) return j;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREQ; i++) begin
            md_rem[i] = '0;
            md_addr[i] = '0;
        end
    endtask

    task automatic start_reqs(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] zmask;
        logic [NREQ-1:0] bmask;
        @(negedge aclk);
        n_tests++;
        if ((req_ready & mask) !== mask) begin
            n_fail++;
            $display("FAIL req_ready: got %b required ones on %b",
                     req_ready, mask);
        end
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i] = st_addr[i];
            req_len[i]  = st_len[i];
            req_dest[i] = st_dest[i];
            req_user[i] = st_user[i];
            req_last[i] = st_last[i];
        end
        req_valid = mask;
        @(negedge aclk);
        req_valid = '0;
        zmask = '0;
        bmask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
                md_addr[i] = st_addr[i] & ~32'h7;
                md_rem[i]  = st_len[i] & ~32'h7;
                md_last[i] = st_last[i];
                md_dest[i] = st_dest[i];
                md_user[i] = st_user[i];
                if (md_rem[i] == 0) zmask[i] = 1'b1;
                else bmask[i] = 1'b1;
            end
        end
        n_tests++;
        if (cmpl !== zmask || busy !== bmask || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accept: cmpl=%b busy=%b m_valid=%b required %b %b 0",
                     cmpl, busy, m_valid, zmask, bmask);
        end
    endtask

    task automatic serve_one(input bit drop_en);
        int g;
        int waited;
        int hold;
        logic [AW-1:0]   exp_len;
        logic            exp_last;
        logic [NREQ-1:0] exp_c;
        logic [AW-1:0]   ca;
        logic [AW-1:0]   cl;
        g = model_pick();
        waited = 0;
        while (m_valid !== 1'b1 && waited < 30) begin
            @(negedge aclk);
            waited++;
        end
        n_tests++;
        if (m_valid !== 1'b1 || g < 0) begin
            n_fail++;
            $display("FAIL wait_valid: m_valid=%b pick=%0d required 1", m_valid, g);
            model_clear();
            return;
        end
        exp_len  = (md_rem[g] > CHUNK) ? AW'(CHUNK) : md_rem[g];
        exp_last = md_last[g] && (md_rem[g] <= CHUNK);
        n_tests++;
        if (m_addr !== md_addr[g]) begin
            n_fail++;
            $display("FAIL m_addr: got %h required %h (port %0d)", m_addr, md_addr[g], g);
        end
        n_tests++;
        if (m_len !== exp_len) begin
            n_fail++;
            $display("FAIL m_len: got %h required %h (port %0d)", m_len, exp_len, g);
        end
        n_tests++;
        if (m_last !== exp_last) begin
            n_fail++;
            $display("FAIL m_last: got %b required %b (port %0d)", m_last, exp_last, g);
        end
        n_tests++;
        if (m_dest !== md_dest[g] || m_user !== md_user[g]) begin
            n_fail++;
            $display("FAIL sideband: got %h/%h required %h/%h (port %0d)",
                     m_dest, m_user, md_dest[g], md_user[g], g);
        end
        if (drop_en) enable = 1'b0;
        ca = m_addr;
        cl = m_len;
        hold = $urandom_range(0, 2);
        repeat (hold) begin
            @(negedge aclk);
            n_tests++;
            if (m_valid !== 1'b1 || m_addr !== ca || m_len !== cl) begin
                n_fail++;
                $display("FAIL stable: valid=%b addr=%h len=%h required 1 %h %h",
                         m_valid, m_addr, m_len, ca, cl);
            end
        end
        m_ready = 1'b1;
        @(negedge aclk);
        m_ready = 1'b0;
        md_addr[g] = md_addr[g] + exp_len;
        md_rem[g]  = md_rem[g] - exp_len;
        md_rr      = (g + 1) % NREQ;
        exp_c = '0;
        if (md_rem[g] == 0) exp_c[g] = 1'b1;
        n_tests++;
        if (m_valid !== 1'b0 || cmpl !== exp_c) begin
            n_fail++;
            $display("FAIL after_ready: m_valid=%b cmpl=%b required 0 %b",
                     m_valid, cmpl, exp_c);
        end
        @(negedge aclk);
        n_tests++;
        if (m_valid !== 1'b0 || cmpl !== '0) begin
            n_fail++;
            $display("FAIL drop_gap: m_valid=%b cmpl=%b required 0 0", m_valid, cmpl);
        end
    endtask

    task automatic run_all();
        int guard;
        guard = 0;
        while (model_pick() >= 0 && guard < 64) begin
            serve_one(1'b0);
            guard++;
        end
        n_tests++;
        if (busy !== '0 || guard >= 64) begin
            n_fail++;
            $display("FAIL drained: busy=%b guard=%0d required 0", busy, guard);
        end
    endtask

    task automatic test_reset();
        areset    = 1'b1;
        enable    = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_len   = '0;
        req_dest  = '0;
        req_user  = '0;
        req_last  = '0;
        m_ready   = 1'b0;
        md_rr     = 0;
        model_clear();
        repeat (3) @(negedge aclk);
        n_tests++;
        if (m_valid !== 1'b0 || busy !== '0 || cmpl !== '0 ||
            m_addr !== '0 || m_len !== '0 || m_last !== 1'b0 ||
            m_dest !== '0 || m_user !== '0 || req_ready !== '1) begin
            n_fail++;
            $display("FAIL reset: v=%b busy=%b cmpl=%b addr=%h len=%h rdy=%b required zeros, rdy all ones",
                     m_valid, busy, cmpl, m_addr, m_len, req_ready);
        end
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_alternate();
        for (int i = 0; i < NREQ; i++) begin
            st_addr[i] = 32'h4000 + 32'h1000 * i;
            st_len[i]  = 32'h400;
            st_last[i] = 1'b1;
            st_dest[i] = DSW'(i);
            st_user[i] = USW'(i + 2);
        end
        start_reqs(3'b011);
        run_all();
    endtask

    task automatic test_single();
        st_addr[0] = 32'h1000;
        st_len[0]  = 32'h600;
        st_last[0] = 1'b1;
        st_dest[0] = 2'd1;
        st_user[0] = 3'd5;
        start_reqs(3'b001);
        run_all();
    endtask

    task automatic test_zero_len();
        bit bad;
        st_addr[0] = 32'h80;
        st_len[0]  = 32'h0;
        st_addr[2] = 32'h55;
        st_len[2]  = 32'h7;
        start_reqs(3'b101);
        bad = 1'b0;
        repeat (6) begin
            @(negedge aclk);
            if (m_valid !== 1'b0 || cmpl !== '0 || busy !== '0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL zero_len_idle: m_valid=%b cmpl=%b busy=%b required 0",
                     m_valid, cmpl, busy);
        end
    endtask

    task automatic test_wrap();
        st_addr[1] = 32'hFFFF_FF04;
        st_len[1]  = 32'h30C;
        st_last[1] = 1'b1;
        st_dest[1] = 2'd3;
        st_user[1] = 3'd7;
        start_reqs(3'b010);
        run_all();
    endtask

    task automatic test_enable();
        bit bad;
        st_addr[2] = 32'h2000;
        st_len[2]  = 32'h400;
        st_last[2] = 1'b0;
        st_dest[2] = 2'd2;
        st_user[2] = 3'd1;
        start_reqs(3'b100);
        serve_one(1'b1);
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_ready = i[0];
            @(negedge aclk);
            if (m_valid !== 1'b0 || cmpl !== '0) bad = 1'b1;
        end
        m_ready = 1'b0;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL enable_low: m_valid=%b cmpl=%b required 0", m_valid, cmpl);
        end
        n_tests++;
        if (busy !== 3'b100) begin
            n_fail++;
            $display("FAIL enable_busy: busy=%b required 100", busy);
        end
        enable = 1'b1;
        run_all();
    endtask

    task automatic test_reset_mid();
        int waited;
        bit bad;
        st_addr[0] = 32'h3000;
        st_len[0]  = 32'h400;
        st_last[0] = 1'b1;
        start_reqs(3'b001);
        waited = 0;
        while (m_valid !== 1'b1 && waited < 30) begin
            @(negedge aclk);
            waited++;
        end
        n_tests++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_wait: m_valid=%b required 1", m_valid);
        end
        areset = 1'b1;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || busy !== '0 || cmpl !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: m_valid=%b busy=%b cmpl=%b required 0",
                     m_valid, busy, cmpl);
        end
        @(negedge aclk);
        areset = 1'b0;
        model_clear();
        md_rr = 0;
        bad = 1'b0;
        repeat (10) begin
            @(negedge aclk);
            if (m_valid !== 1'b0 || busy !== '0 || cmpl !== '0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_quiet: m_valid=%b busy=%b cmpl=%b required 0",
                     m_valid, busy, cmpl);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask;
        for (int r = 0; r < 20; r++) begin
            mask = NREQ'($urandom_range(1, 7));
            for (int i = 0; i < NREQ; i++) begin
                st_addr[i] = $urandom;
                st_len[i]  = ($urandom_range(0, 5) == 0) ?
                             AW'($urandom_range(0, 7)) :
                             AW'($urandom_range(0, 32'h900));
                st_last[i] = 1'($urandom_range(0, 1));
                st_dest[i] = DSW'($urandom);
                st_user[i] = USW'($urandom);
            end
            start_reqs(mask);
            run_all();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_zero_len();
        test_wrap();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
